// File: rtl/heater_pkg.sv
// Shared types for the rp_heater ring bank: controller state encoding and a
// constant-width helper used to size counters from parameters.
package heater_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   // Bits needed to hold values 0..value-1 (0 for value<=1).
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/heater_ring.sv
// One heater ring: a NAND-gated inverter loop in silicon, replaced in
// simulation by a register toggling every clk while enabled.
module heater_ring #(
   parameter int STAGES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic osc_out
);

   if ((STAGES < 3) || ((STAGES % 2) == 0)) begin : g_bad_stages
      $error("heater_ring: STAGES must be odd and >= 3");
   end

`ifdef SYNTHESIS
   // The loop must survive optimisation intact; clk and rst are unused here.
   (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] node;

   assign node[0] = ~(en & node[STAGES-1]);
   for (genvar g = 1; g < STAGES; g++) begin : g_inv
      assign node[g] = ~node[g-1];
   end
   assign osc_out = node[STAGES-1];
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     osc_out <= 1'b0;
      else if (en) osc_out <= ~osc_out;
   end
`endif

endmodule

// File: rtl/heater_ring_bank.sv
// Bank of ring-oscillator heaters: staggered admit/remove FSM, PWM gating of
// the admitted rings, and a per-ring liveness monitor on the ring outputs.
module heater_ring_bank
   import heater_pkg::*;
#(
   parameter int NUM_RINGS      = 8,
   parameter int RING_STAGES    = 5,
   parameter int PWM_BITS       = 8,
   parameter int STAGGER_CYCLES = 16,
   parameter int MON_WINDOW     = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [PWM_BITS-1:0]  duty,
   input  logic [NUM_RINGS-1:0] ring_mask,
   output logic [NUM_RINGS-1:0] ring_on,
   output logic                 running,
   output logic                 ramp_done,
   output logic [NUM_RINGS-1:0] ring_alive
);

   localparam int AW = clog2(NUM_RINGS + 1);
   localparam int TW = (STAGGER_CYCLES > 1) ? clog2(STAGGER_CYCLES) : 1;
   localparam int WW = clog2(MON_WINDOW);
   localparam logic [AW-1:0] ADMIT_MAX  = AW'(NUM_RINGS);
   localparam logic [TW-1:0] TIMER_LAST = TW'(STAGGER_CYCLES - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(MON_WINDOW - 1);

   state_t                state;
   logic [AW-1:0]         admitted;
   logic [TW-1:0]         timer;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic                  pwm_on;
   logic [NUM_RINGS-1:0]  admit_mask;
   logic [NUM_RINGS-1:0]  ring_on_next;

   always_comb begin
      admit_mask = '0;
      pwm_on     = (&duty) | (pwm_cnt < duty);
      for (int i = 0; i < NUM_RINGS; i++) admit_mask[i] = (i < int'(admitted));
      ring_on_next = admit_mask & ring_mask & {NUM_RINGS{pwm_on}};
   end

   // A state change on the same edge as a timer wrap takes priority, so the
   // admitted count is left alone on that cycle.
   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         admitted  <= '0;
         timer     <= '0;
         ramp_done <= 1'b0;
      end else begin
         ramp_done <= (state == RUN);
         case (state)
            IDLE: begin
               admitted <= '0;
               timer    <= '0;
               if (enable) state <= RAMP_UP;
            end
            RAMP_UP: begin
               if (!enable) begin
                  state <= RAMP_DOWN;
                  timer <= '0;
               end else if (admitted == ADMIT_MAX) begin
                  state <= RUN;
                  timer <= '0;
               end else if (timer == TIMER_LAST) begin
                  timer    <= '0;
                  admitted <= admitted + 1'b1;
                  if (admitted == ADMIT_MAX - 1'b1) state <= RUN;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  state <= RAMP_DOWN;
                  timer <= '0;
               end
            end
            RAMP_DOWN: begin
               if (enable) begin
                  state <= RAMP_UP;
                  timer <= '0;
               end else if (admitted == '0) begin
                  state <= IDLE;
               end else if (timer == TIMER_LAST) begin
                  timer    <= '0;
                  admitted <= admitted - 1'b1;
                  if (admitted == AW'(1)) state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
         ring_on <= '0;
         running <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         ring_on <= ring_on_next;
         running <= |ring_on_next;
      end
   end

   logic [NUM_RINGS-1:0] osc;

   for (genvar g = 0; g < NUM_RINGS; g++) begin : g_ring
      heater_ring #(.STAGES(RING_STAGES)) u_ring (
         .clk     (clk),
         .rst     (rst),
         .en      (ring_on[g]),
         .osc_out (osc[g])
      );
   end

   // Ring outputs are asynchronous to clk: two flops resynchronise, the third
   // holds the previous sample for edge detection.
   logic [NUM_RINGS-1:0] sync1, sync2, sync3;
   logic [NUM_RINGS-1:0] osc_edge;
   logic [1:0]           toggles [NUM_RINGS];
   logic [WW-1:0]        win_cnt;

   assign osc_edge = sync2 ^ sync3;

   // NOTE: the toggle counters are a handful of flops, so they take the
   // asynchronous reset like all other state instead of being left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         sync3      <= '0;
         win_cnt    <= '0;
         ring_alive <= '0;
         for (int i = 0; i < NUM_RINGS; i++) toggles[i] <= 2'd0;
      end else begin
         sync1 <= osc;
         sync2 <= sync1;
         sync3 <= sync2;
         if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            for (int i = 0; i < NUM_RINGS; i++) begin
               ring_alive[i] <= toggles[i][1];
               toggles[i]    <= 2'd0;
            end
         end else begin
            win_cnt <= win_cnt + 1'b1;
            for (int i = 0; i < NUM_RINGS; i++) begin
               if (osc_edge[i] && (toggles[i] != 2'd3)) toggles[i] <= toggles[i] + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_heater_ring_bank.sv
// Directed bench for heater_ring_bank: ramp timing, PWM gating, mask, liveness,
// ramp-down/resume, wrap-vs-enable priority and asynchronous reset.
module tb_heater_ring_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] duty;
   logic [7:0] ring_mask;
   logic [7:0] ring_on;
   logic       running;
   logic       ramp_done;
   logic [7:0] ring_alive;

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned edges;

   heater_ring_bank #(
      .NUM_RINGS      (8),
      .RING_STAGES    (5),
      .PWM_BITS       (8),
      .STAGGER_CYCLES (16),
      .MON_WINDOW     (256)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .duty       (duty),
      .ring_mask  (ring_mask),
      .ring_on    (ring_on),
      .running    (running),
      .ramp_done  (ramp_done),
      .ring_alive (ring_alive)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the DUT PWM counter equals edges mod 256.
   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] exp8;
      rst       = 1'b1;
      enable    = 1'b0;
      duty      = 8'hFF;
      ring_mask = 8'hFF;
      step(2);
      check("rst_ring_on",    ring_on,    8'h00);
      check("rst_running",    running,    1'b0);
      check("rst_ramp_done",  ramp_done,  1'b0);
      check("rst_ring_alive", ring_alive, 8'h00);
      rst = 1'b0;
      step(3);
      check("idle_ring_on", ring_on, 8'h00);

      // Staggered ramp: ring k appears 16*(k+1)+1 edges after enable is sampled.
      enable = 1'b1;
      step(17);
      check("t1_before_ring0", ring_on, 8'h00);
      step(1);
      check("t1_ring0", ring_on, 8'h01);
      check("t1_running", running, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         step(16);
         exp8 = 8'((1 << (k + 1)) - 1);
         check("t1_ramp", ring_on, exp8);
      end
      step(15);
      check("t1_before_ring7", ring_on, 8'h7F);
      check("t1_ramp_done_lo", ramp_done, 1'b0);
      step(1);
      check("t1_ring7", ring_on, 8'hFF);
      check("t1_ramp_done_hi", ramp_done, 1'b1);

      // PWM quarter duty: on while the pre-edge counter value is below 0x40.
      duty = 8'h40;
      for (int i = 0; i < 256; i++) begin
         step(1);
         exp8 = (((edges - 1) % 256) < 64) ? 8'hFF : 8'h00;
         check("t2_pwm40", ring_on, exp8);
      end
      duty = 8'h00;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("t2_duty0_ring_on", ring_on, 8'h00);
         check("t2_duty0_running", running, 1'b0);
      end

      // Mask applies on the next edge without stagger; liveness follows it.
      duty      = 8'hFF;
      ring_mask = 8'hA5;
      step(1);
      check("t4_mask", ring_on, 8'hA5);
      check("t4_running", running, 1'b1);
      step(2 * 256 + 4);
      check("t4_alive", ring_alive, 8'hA5);

      // Full ramp-down to IDLE, then partial ramp, removal and resume.
      ring_mask = 8'hFF;
      enable    = 1'b0;
      step(140);
      check("t3_idle_ring_on", ring_on, 8'h00);
      check("t3_idle_running", running, 1'b0);
      check("t3_idle_ramp_done", ramp_done, 1'b0);
      enable = 1'b1;
      step(50);
      check("t3_three_rings", ring_on, 8'h07);
      enable = 1'b0;
      step(17);
      check("t3_hold_before_drop", ring_on, 8'h07);
      step(1);
      check("t3_drop_ring2", ring_on, 8'h03);
      step(8);
      enable = 1'b1;
      step(17);
      check("t3_resume_hold", ring_on, 8'h03);
      step(1);
      check("t3_resume_ring2", ring_on, 8'h07);
      enable = 1'b0;
      step(17);
      check("t3_down_hold", ring_on, 8'h07);
      step(1);
      check("t3_down_ring2", ring_on, 8'h03);
      step(16);
      check("t3_down_ring1", ring_on, 8'h01);
      step(16);
      check("t3_down_ring0", ring_on, 8'h00);
      check("t3_down_running", running, 1'b0);

      // Enable drop exactly on the stagger wrap that would admit ring 1.
      step(3);
      enable = 1'b1;
      step(32);
      check("t6_one_ring", ring_on, 8'h01);
      enable = 1'b0;
      step(2);
      check("t6_wrap_no_admit", ring_on, 8'h01);
      step(15);
      check("t6_hold", ring_on, 8'h01);
      step(1);
      check("t6_removed", ring_on, 8'h00);

      // Asynchronous reset mid-ramp clears outputs before the next edge.
      step(3);
      enable = 1'b1;
      step(34);
      check("t5_two_rings", ring_on, 8'h03);
      #1 rst = 1'b1;
      #1;
      check("t5_async_ring_on",   ring_on,    8'h00);
      check("t5_async_running",   running,    1'b0);
      check("t5_async_ramp_done", ramp_done,  1'b0);
      check("t5_async_alive",     ring_alive, 8'h00);
      #1 rst = 1'b0;
      step(17);
      check("t5_reramp_before", ring_on, 8'h00);
      step(1);
      check("t5_reramp_ring0", ring_on, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
